// File: rtl/dds_pkg.sv
// Shared definitions for the DDS voice bank: frame FSM states and default sizing.
package dds_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam int DEF_NUM_VOICES = 4;
    localparam int DEF_PHASE_W    = 32;
    localparam int DEF_LUT_ADDR_W = 6;
    localparam int DEF_AMP_W      = 8;

endpackage

// File: rtl/dds_qlut.sv
// Quarter-wave sine magnitude table, entries 0..2^LUT_ADDR_W inclusive, registered output.
module dds_qlut
    import dds_pkg::*;
#(
    parameter int LUT_ADDR_W = DEF_LUT_ADDR_W,
    parameter int AMP_W      = DEF_AMP_W
) (
    input  logic                  clk,
    input  logic [LUT_ADDR_W:0]   idx,
    output logic [AMP_W-2:0]      mag
);

    localparam int QN = (1 << LUT_ADDR_W) + 1;

    // Elaboration-time sine via Taylor series; x never exceeds pi/2 so it converges fast.
    function automatic int qval(input int k);
        real x, term, s;
        x    = 3.14159265358979323846 * real'(k) / real'(1 << (LUT_ADDR_W + 1));
        term = x;
        s    = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / (real'(2 * n) * real'(2 * n + 1));
            s    = s + term;
        end
        return $rtoi(real'((1 << (AMP_W - 1)) - 1) * s + 0.5);
    endfunction

    logic [AMP_W-2:0] rom [QN];

    for (genvar i = 0; i < QN; i++) begin : g_rom
        localparam logic [AMP_W-2:0] QV = (AMP_W-1)'(qval(i));
        assign rom[i] = QV;
    end

    always_ff @(posedge clk) begin
        mag <= rom[idx];
    end

endmodule

// File: rtl/dds_voice_bank.sv
// Time-multiplexed sine voice bank: one voice per cycle through a shared quarter-wave table,
// summed into one mixed sample per step_in.
module dds_voice_bank
    import dds_pkg::*;
#(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int PHASE_W    = DEF_PHASE_W,
    parameter int LUT_ADDR_W = DEF_LUT_ADDR_W,
    parameter int AMP_W      = DEF_AMP_W,
    localparam int VID_W     = $clog2(NUM_VOICES),
    localparam int OUT_W     = AMP_W + VID_W
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    step_in,
    input  logic                    cfg_valid_in,
    input  logic [VID_W-1:0]        cfg_voice_in,
    input  logic [PHASE_W-1:0]      cfg_incr_in,
    input  logic                    cfg_enable_in,
    input  logic [2:0]              cfg_shift_in,
    output logic signed [OUT_W-1:0] mix_out,
    output logic                    mix_valid_out,
    output logic                    busy_out,
    output logic                    overrun_out
);

    localparam logic [LUT_ADDR_W:0] QTOP = (LUT_ADDR_W+1)'(1 << LUT_ADDR_W);

    state_t state, state_nxt;
    logic [VID_W-1:0] vid;
    logic [1:0]       dcnt;

    logic [PHASE_W-1:0] phase    [NUM_VOICES];
    logic [PHASE_W-1:0] sh_incr  [NUM_VOICES];
    logic [PHASE_W-1:0] act_incr [NUM_VOICES];
    logic [PHASE_W-1:0] sn_incr  [NUM_VOICES];
    logic               sh_en    [NUM_VOICES];
    logic               act_en   [NUM_VOICES];
    logic               sn_en    [NUM_VOICES];
    logic [2:0]         sh_shift [NUM_VOICES];
    logic [2:0]         act_shift[NUM_VOICES];
    logic [2:0]         sn_shift [NUM_VOICES];

    logic                    start;
    logic [LUT_ADDR_W+1:0]   full;
    logic [LUT_ADDR_W-1:0]   k;
    logic [LUT_ADDR_W:0]     idx;
    logic [AMP_W-2:0]        mag;
    logic                    s1_valid, s1_neg, s1_en;
    logic [2:0]              s1_shift;
    logic signed [AMP_W-1:0] amp, sh_amp;
    logic signed [OUT_W-1:0] contrib, acc;

    assign start    = (state == IDLE) && step_in;
    assign busy_out = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (step_in) state_nxt = RUN;
            RUN:     if (vid == VID_W'(NUM_VOICES - 1)) state_nxt = DRAIN;
            DRAIN:   if (dcnt == 2'd2) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
            vid   <= '0;
            dcnt  <= '0;
        end else begin
            state <= state_nxt;
            vid   <= (state == RUN) ? vid + 1'b1 : '0;
            dcnt  <= (state == DRAIN) ? dcnt + 2'd1 : '0;
        end
    end

    // Shadow view including a same-cycle write, so a write at frame start lands in that frame.
    always_comb begin
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            sn_incr[i]  = sh_incr[i];
            sn_en[i]    = sh_en[i];
            sn_shift[i] = sh_shift[i];
            if (cfg_valid_in && cfg_voice_in == VID_W'(i)) begin
                sn_incr[i]  = cfg_incr_in;
                sn_en[i]    = cfg_enable_in;
                sn_shift[i] = cfg_shift_in;
            end
        end
    end

    always_comb begin
        full = phase[vid][PHASE_W-1 -: LUT_ADDR_W+2];
        k    = full[LUT_ADDR_W-1:0];
        idx  = full[LUT_ADDR_W] ? QTOP - {1'b0, k} : {1'b0, k};
    end

    dds_qlut #(
        .LUT_ADDR_W (LUT_ADDR_W),
        .AMP_W      (AMP_W)
    ) u_qlut (
        .clk (clk_in),
        .idx (idx),
        .mag (mag)
    );

    // Sign, enable and shift travel one stage alongside the registered table read.
    always_comb begin
        amp     = s1_neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
        sh_amp  = amp >>> s1_shift;
        contrib = s1_en ? {{VID_W{sh_amp[AMP_W-1]}}, sh_amp} : '0;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_valid      <= 1'b0;
            s1_neg        <= 1'b0;
            s1_en         <= 1'b0;
            s1_shift      <= '0;
            acc           <= '0;
            mix_out       <= '0;
            mix_valid_out <= 1'b0;
            overrun_out   <= 1'b0;
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                phase[i]     <= '0;
                sh_incr[i]   <= '0;
                act_incr[i]  <= '0;
                sh_en[i]     <= 1'b0;
                act_en[i]    <= 1'b0;
                sh_shift[i]  <= '0;
                act_shift[i] <= '0;
            end
        end else begin
            overrun_out   <= step_in && busy_out;
            mix_valid_out <= 1'b0;
            s1_valid      <= (state == RUN);
            s1_neg        <= full[LUT_ADDR_W+1];
            s1_en         <= act_en[vid];
            s1_shift      <= act_shift[vid];
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                sh_incr[i]  <= sn_incr[i];
                sh_en[i]    <= sn_en[i];
                sh_shift[i] <= sn_shift[i];
                if (start) begin
                    act_incr[i]  <= sn_incr[i];
                    act_en[i]    <= sn_en[i];
                    act_shift[i] <= sn_shift[i];
                end
            end
            if (state == RUN)
                phase[vid] <= act_en[vid] ? phase[vid] + act_incr[vid] : '0;
            if (start)
                acc <= '0;
            else if (s1_valid)
                acc <= acc + contrib;
            if (state == DRAIN && dcnt == 2'd1) begin
                mix_out       <= acc;
                mix_valid_out <= 1'b1;
            end
        end
    end

endmodule

// File: doc/dds_voice_bank.md
DDS_VOICE_BANK -- requirements
Module: dds_voice_bank

Interface
REQ-001 Parameter NUM_VOICES, default 4: number of time-multiplexed sine voices (power of 2, at least 2).
REQ-002 Parameter PHASE_W, default 32: phase accumulator width per voice.
REQ-003 Parameter LUT_ADDR_W, default 6: quarter-wave table address width; full-cycle resolution is LUT_ADDR_W+2 bits.
REQ-004 Parameter AMP_W, default 8: signed per-voice amplitude width.
REQ-005 Derived localparams: VID_W = clog2(NUM_VOICES); OUT_W = AMP_W+VID_W.
REQ-006 Port clk_in, input, 1: the single clock.
REQ-007 Port rst_in, input, 1: synchronous active-high reset.
REQ-008 Port step_in, input, 1: sample-rate strobe that requests one mixed sample.
REQ-009 Port cfg_valid_in, input, 1: configuration write strobe.
REQ-010 Port cfg_voice_in, input, VID_W: index of the voice being written.
REQ-011 Port cfg_incr_in, input, PHASE_W: phase increment for that voice.
REQ-012 Port cfg_enable_in, input, 1: voice enable (note on) for that voice.
REQ-013 Port cfg_shift_in, input, 3: arithmetic right-shift attenuation for that voice.
REQ-014 Port mix_out, output, OUT_W signed: sum of all voice contributions.
REQ-015 Port mix_valid_out, output, 1: one-cycle pulse marking a new mix_out.
REQ-016 Port busy_out, output, 1: high while a frame is in progress.
REQ-017 Port overrun_out, output, 1: one-cycle pulse when a step_in is dropped.

Function
REQ-018 The FSM SHALL have three states: IDLE, RUN, DRAIN.
- IDLE -> RUN when step_in=1.
- RUN lasts NUM_VOICES cycles, processing voice index 0..NUM_VOICES-1 in order, one per cycle.
- DRAIN lasts 3 cycles, then returns to IDLE.
REQ-019 busy_out SHALL be high from cycle t+1 through t+NUM_VOICES+3 inclusive, where step_in is accepted in cycle t.
REQ-020 mix_valid_out SHALL pulse for exactly one cycle at t+NUM_VOICES+3; mix_out SHALL hold its value until the next pulse.
REQ-021 A step_in while busy_out=1 SHALL be ignored, and overrun_out SHALL pulse on the following cycle.
REQ-022 Configuration writes SHALL go to shadow registers at any time, and SHALL be copied to the active registers in cycle t (frame start) only.
REQ-023 A cfg write coinciding with frame start SHALL be included in that frame.
REQ-024 Voice lookup:
- The voice's current phase is used before it is updated.
- The full-cycle address is phase[PHASE_W-1 -: LUT_ADDR_W+2].
- The top address bit is the sign (negate), the next bit is the mirror (index = 2^LUT_ADDR_W - k), and k is the low LUT_ADDR_W bits.
REQ-025 Quarter table entry Q[k] SHALL equal round((2^(AMP_W-1)-1)*sin(pi*k/2^(LUT_ADDR_W+1))) for k = 0..2^LUT_ADDR_W.
- Output range is symmetric, ±(2^(AMP_W-1)-1).
- The most negative code is never produced.
REQ-026 An enabled voice's contribution SHALL be (signed amplitude >>> shift), and its phase SHALL then advance by incr modulo 2^PHASE_W (natural wrap).
REQ-027 A disabled voice SHALL contribute 0, and its phase SHALL be forced to 0, so that re-enabling starts at phase 0.
REQ-028 The accumulator SHALL be OUT_W wide; overflow is impossible by construction, and no saturation is applied.

Reset
REQ-029 On rst_in=1 at a clock edge, the block SHALL enter IDLE and clear:
- mix_out, mix_valid_out, busy_out, overrun_out;
- all phases;
- all active and shadow incr, enable and shift registers (all voices disabled).
REQ-030 A reset mid-frame SHALL abort the frame with no mix_valid_out pulse.
REQ-031 step_in during reset SHALL be ignored.

Structure
REQ-032 Package dds_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-033 One sub-module, dds_qlut, SHALL hold the quarter-wave table with a registered output (1-cycle latency) and SHALL be instantiated once and shared across voices.

Verification (NUM_VOICES=4, PHASE_W=32, LUT_ADDR_W=6, AMP_W=8)
REQ-034 Reset: hold rst_in for 3 cycles -> all outputs 0; a step_in in the next cycle -> mix_valid_out 7 cycles later with mix_out=0.
REQ-035 Single voice: voice0 incr=0x4000_0000, enable=1, shift=0, then 4 steps -> mix_out sequence 0, 127, 0, -127.
REQ-036 Four voices: all with incr=0x4000_0000 and shift=0 -> second frame mix_out=508; with shift=2 -> second frame 124, fourth frame -128.
REQ-037 Overrun: step_in at cycles t and t+2 -> one mix_valid_out at t+7, overrun_out pulse at t+3, busy_out high t+1..t+7.
REQ-038 Config during frame: write voice1 enable at t+2 -> frame t output excludes voice1, next frame includes it starting at phase 0.
REQ-039 Reset mid-frame: rst_in at t+3 -> busy_out=0 at t+4, no mix_valid_out; the next step_in produces a normal frame.
